// File: rtl/mux_lab_pkg.sv
// Shared widths and state encodings for the mux select controller.
package mux_lab_pkg;

    localparam int unsigned DATA_W   = 4;
    localparam int unsigned TOGGLE_W = 8;

    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] AUTO   = 1'b1;

endpackage

// File: rtl/mux_sel_ctrl_if.sv
// Operand, select and status bundle between the controller and its environment.
interface mux_sel_ctrl_if;
    import mux_lab_pkg::*;

    logic                btn;
    logic                auto_en;
    logic                load;
    logic [DATA_W-1:0]   a_in;
    logic [DATA_W-1:0]   b_in;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                Sel;
    logic                sel_changed;
    logic [TOGGLE_W-1:0] toggle_cnt;

    modport master (
        output btn, auto_en, load, a_in, b_in,
        input  a, b, Sel, sel_changed, toggle_cnt
    );

    modport slave (
        input  btn, auto_en, load, a_in, b_in,
        output a, b, Sel, sel_changed, toggle_cnt
    );

endinterface

// File: rtl/mux_sel_ctrl_btn_debounce.sv
// Push-button synchronizer, debouncer and rising-edge detector.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync_m_q, sync_s_q;
    logic            db_q, db_d;
    logic            db_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level must disagree for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_s_q != db_q) begin
            if (cnt_q == CntMax) begin
                db_d = sync_s_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m_q  <= 1'b0;
            sync_s_q  <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_m_q  <= raw;
            sync_s_q  <= sync_m_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign level = db_q;
    assign rise  = db_q & ~db_prev_q;

endmodule

// File: rtl/mux_sel_ctrl.sv
// 2:1 mux operand/select controller: manual button toggling or timed auto alternation.
module mux_sel_ctrl
    import mux_lab_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned AUTO_PERIOD     = 100000000
) (
    input logic           clk,
    input logic           rst,
    mux_sel_ctrl_if.slave bus
);

    localparam int unsigned PerW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PerW-1:0] PerMax = PerW'(AUTO_PERIOD - 1);

    logic                auto_m_q, auto_s_q;
    logic [0:0]          state_q, state_d;
    logic [PerW-1:0]     per_q, per_d;
    logic                sel_q, sel_d;
    logic                sel_changed_q;
    logic [TOGGLE_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic                btn_level, btn_rise, press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.btn),
        .level(btn_level),
        .rise (btn_rise)
    );

    assign press = btn_rise & btn_level;

    // A mode change has priority over a toggle arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        sel_d   = sel_q;
        case (state_q)
            MANUAL: begin
                per_d = '0;
                if (auto_s_q) begin
                    state_d = AUTO;
                end else if (press) begin
                    sel_d = ~sel_q;
                end
            end
            AUTO: begin
                if (!auto_s_q) begin
                    state_d = MANUAL;
                    per_d   = '0;
                end else if (per_q == PerMax) begin
                    per_d = '0;
                    sel_d = ~sel_q;
                end else begin
                    per_d = per_q + PerW'(1);
                end
            end
            default: begin
                state_d = MANUAL;
                per_d   = '0;
            end
        endcase
    end

    assign toggle_cnt_d = toggle_cnt_q + TOGGLE_W'(sel_d ^ sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_m_q      <= 1'b0;
            auto_s_q      <= 1'b0;
            state_q       <= MANUAL;
            per_q         <= '0;
            sel_q         <= 1'b0;
            sel_changed_q <= 1'b0;
            toggle_cnt_q  <= '0;
        end else begin
            auto_m_q      <= bus.auto_en;
            auto_s_q      <= auto_m_q;
            state_q       <= state_d;
            per_q         <= per_d;
            sel_q         <= sel_d;
            sel_changed_q <= sel_d ^ sel_q;
            toggle_cnt_q  <= toggle_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (bus.load) begin
            a_q <= bus.a_in;
            b_q <= bus.b_in;
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.Sel         = sel_q;
    assign bus.sel_changed = sel_changed_q;
    assign bus.toggle_cnt  = toggle_cnt_q;

endmodule
